// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a port index; at least one bit so a degenerate count still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending port at or after the rr pointer wins.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IW-1:0]      rr,
  output logic               vld,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0] idx;

  always_comb begin
    vld     = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(rr) + 32'(k)) % 32'(NUM_REQ));
      if (!vld && pend[idx]) begin
        vld         = 1'b1;
        gnt_idx     = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter: buffers one request per port and issues them to a shared
// memory port one transaction at a time, returning a registered ack to the originator.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     clk_i,
  input  logic                                     arst_i,
  input  logic [NUM_REQ-1:0]                       req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]       addr_i,
  input  logic [NUM_REQ-1:0]                       we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]     strb_i,
  output logic [NUM_REQ-1:0]                       ack_o,
  output logic [DATA_WIDTH-1:0]                    rdata_o,
  output logic                                     resp_o,
  output logic                                     mreq_o,
  output logic [ADDR_WIDTH-1:0]                    maddr_o,
  output logic                                     mwe_o,
  output logic [DATA_WIDTH-1:0]                    mwdata_o,
  output logic [DATA_WIDTH/8-1:0]                  mstrb_o,
  input  logic                                     mack_i,
  input  logic [DATA_WIDTH-1:0]                    mrdata_i,
  input  logic                                     mresp_i
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0]                   pend_q;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_q;
  logic [NUM_REQ-1:0]                   we_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_q;
  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] strb_q;

  logic [IW-1:0]      rr_q, grant_q, pick_idx, sel_idx, done_idx;
  logic [NUM_REQ-1:0] pick_oh, done_oh;
  logic               pick_vld, done;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .pend    (pend_q),
    .rr      (rr_q),
    .vld     (pick_vld),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    mreq_o   = 1'b0;
    done     = 1'b0;
    done_idx = grant_q;
    done_oh  = '0;
    sel_idx  = grant_q;
    case (state_q)
      IDLE: begin
        sel_idx = pick_vld ? pick_idx : rr_q;
        if (pick_vld) begin
          mreq_o   = 1'b1;
          done_idx = pick_idx;
          done_oh  = pick_oh;
          // A zero-wait memory completes in the issue cycle, so no BUSY detour.
          if (mack_i) done = 1'b1;
          else        state_d = BUSY;
        end
      end
      BUSY: begin
        done_oh = NUM_REQ'(1) << grant_q;
        if (mack_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign maddr_o  = addr_q[sel_idx];
  assign mwe_o    = we_q[sel_idx];
  assign mwdata_o = wdata_q[sel_idx];
  assign mstrb_o  = strb_q[sel_idx];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      ack_o   <= '0;
      rdata_o <= '0;
      resp_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld && !mack_i) grant_q <= pick_idx;
      if (done) begin
        rr_q    <= (done_idx == IW'(NUM_REQ - 1)) ? '0 : done_idx + 1'b1;
        rdata_o <= mrdata_i;
        resp_o  <= mresp_i;
      end
      ack_o <= done ? done_oh : '0;
    end
  end

  // Completion only clears a set flag and capture only fills a clear one, so they never collide.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_q  <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done && done_oh[i]) begin
          pend_q[i] <= 1'b0;
        end else if (req_i[i] && !pend_q[i]) begin
          pend_q[i]  <= 1'b1;
          addr_q[i]  <= addr_i[i];
          we_q[i]    <= we_i[i];
          wdata_q[i] <= wdata_i[i];
          strb_q[i]  <= strb_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arst_i) begin
        assert (!(req_i[i] && pend_q[i]))
          else $warning("mem_rr_arbiter: request on port %0d while pending, ignored", i);
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: a 2-port instance for directed cases and a
// 3-port instance for round-robin fairness under continuous re-requests.
module tb_mem_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [1:0]         req_a, we_a, ack_a;
  logic [1:0][AW-1:0] addr_a;
  logic [1:0][DW-1:0] wdata_a;
  logic [1:0][SW-1:0] strb_a;
  logic [DW-1:0]      rdata_a, mwdata_a, mrdata_a;
  logic [AW-1:0]      maddr_a;
  logic [SW-1:0]      mstrb_a;
  logic               resp_a, mreq_a, mwe_a, mack_a, mresp_a;

  logic [2:0]         req_b, we_b, ack_b;
  logic [2:0][AW-1:0] addr_b;
  logic [2:0][DW-1:0] wdata_b;
  logic [2:0][SW-1:0] strb_b;
  logic [DW-1:0]      rdata_b, mwdata_b, mrdata_b;
  logic [AW-1:0]      maddr_b;
  logic [SW-1:0]      mstrb_b;
  logic               resp_b, mreq_b, mwe_b, mack_b, mresp_b;

  mem_rr_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_a (
    .clk_i(clk), .arst_i(arst), .req_i(req_a), .addr_i(addr_a), .we_i(we_a),
    .wdata_i(wdata_a), .strb_i(strb_a), .ack_o(ack_a), .rdata_o(rdata_a), .resp_o(resp_a),
    .mreq_o(mreq_a), .maddr_o(maddr_a), .mwe_o(mwe_a), .mwdata_o(mwdata_a), .mstrb_o(mstrb_a),
    .mack_i(mack_a), .mrdata_i(mrdata_a), .mresp_i(mresp_a)
  );

  mem_rr_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_b (
    .clk_i(clk), .arst_i(arst), .req_i(req_b), .addr_i(addr_b), .we_i(we_b),
    .wdata_i(wdata_b), .strb_i(strb_b), .ack_o(ack_b), .rdata_o(rdata_b), .resp_o(resp_b),
    .mreq_o(mreq_b), .maddr_o(maddr_b), .mwe_o(mwe_b), .mwdata_o(mwdata_b), .mstrb_o(mstrb_b),
    .mack_i(mack_b), .mrdata_i(mrdata_b), .mresp_i(mresp_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } mreq_t;

  typedef struct packed {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic          resp;
  } ack_t;

  mreq_t exp_req_q[$];
  ack_t  exp_ack_q[$];
  int    exp_b_gnt_q[$];
  int    exp_b_ack_q[$];
  mreq_t mon_r;
  ack_t  mon_k;
  int    mon_p;

  // Memory model for instance A: wait 0 acks alongside mreq, wait n acks n cycles later.
  int            mem_wait  = 0;
  int            mem_cnt   = 0;
  bit            mem_busy  = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_resp  = 1'b0;

  always @(negedge clk) begin
    mack_a = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mack_a   = 1'b1;
        mem_busy = 1'b0;
      end
    end else if (mreq_a && !arst) begin
      if (mem_wait == 0) mack_a = 1'b1;
      else begin
        mem_busy = 1'b1;
        mem_cnt  = mem_wait;
      end
    end
    mrdata_a = mem_rdata;
    mresp_a  = mem_resp;
  end

  always @(negedge clk) begin
    mack_b   = mreq_b;
    mrdata_b = '0;
    mresp_b  = 1'b0;
  end

  always @(negedge clk) begin
    if (mreq_a) begin
      if (exp_req_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_mreq_a: maddr 0x%0h, expected no request", maddr_a);
      end else begin
        mon_r = exp_req_q.pop_front();
        chk("mreq_addr", maddr_a, mon_r.addr);
        chk("mreq_we", mwe_a, mon_r.we);
        chk("mreq_wdata", mwdata_a, mon_r.wdata);
        chk("mreq_strb", mstrb_a, mon_r.strb);
      end
    end
    if (ack_a != 2'b00) begin
      if (exp_ack_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ack_a: ack_o 0x%0h, expected none", ack_a);
      end else begin
        mon_k = exp_ack_q.pop_front();
        chk("ack_vec", ack_a, mon_k.ack);
        chk("ack_rdata", rdata_a, mon_k.rdata);
        chk("ack_resp", resp_a, mon_k.resp);
      end
    end
    if (mreq_b) begin
      if (exp_b_gnt_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_mreq_b: maddr 0x%0h, expected no request", maddr_b);
      end else begin
        mon_p = exp_b_gnt_q.pop_front();
        chk("b_grant_addr", maddr_b, 64'((mon_p + 1) * 256));
      end
    end
    if (ack_b != 3'b000) begin
      if (exp_b_ack_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ack_b: ack_o 0x%0h, expected none", ack_b);
      end else begin
        mon_p = exp_b_ack_q.pop_front();
        chk("b_ack_vec", ack_b, 64'(1 << mon_p));
      end
    end
  end

  // Instance B traffic: all ports request once, then each re-requests in its ack cycle.
  bit   b_start   = 1'b0;
  bit   b_started = 1'b0;
  int   b_cnt[3]  = '{0, 0, 0};
  logic [2:0] b_nr;

  always @(negedge clk) begin
    b_nr = '0;
    if (b_start && !b_started) begin
      b_started = 1'b1;
      b_nr      = 3'b111;
      for (int i = 0; i < 3; i++) b_cnt[i] = 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (ack_b[i] && b_cnt[i] < 2) begin
        b_nr[i] = 1'b1;
        b_cnt[i]++;
      end
    end
    req_b = b_nr;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    arst = 1'b0;
  endtask

  task automatic issue_a(input int p, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_a[p]   = 1'b1;
    addr_a[p]  = a;
    we_a[p]    = w;
    wdata_a[p] = d;
    strb_a[p]  = s;
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    mreq_t r;
    r.addr = a; r.we = w; r.wdata = d; r.strb = s;
    exp_req_q.push_back(r);
  endtask

  task automatic push_ack(input logic [1:0] v, input logic [DW-1:0] d, input logic e);
    ack_t k;
    k.ack = v; k.rdata = d; k.resp = e;
    exp_ack_q.push_back(k);
  endtask

  task automatic wait_mreq_a(input string name);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!mreq_a && i < 10);
    if (!mreq_a) begin
      n_chk++; n_fail++;
      $display("FAIL %s: mreq_o never rose within 10 cycles, expected a request", name);
    end
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_ack_q.size() != 0 || exp_req_q.size() != 0) && i < 40) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    n_chk++;
    if (exp_ack_q.size() != 0 || exp_req_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d acks and %0d requests still outstanding, expected 0",
               name, exp_ack_q.size(), exp_req_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    req_a = '0; addr_a = '0; we_a = '0; wdata_a = '0; strb_a = '0;
    we_b = '0; wdata_b = '0; strb_b = '0;
    for (int i = 0; i < 3; i++) addr_b[i] = AW'((i + 1) * 256);
    repeat (2) @(negedge clk);
    chk("rst_ack", ack_a, 0);
    chk("rst_mreq", mreq_a, 0);
    chk("rst_maddr", maddr_a, 0);
    chk("rst_mwdata", mwdata_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_resp", resp_a, 0);
    tick();
    arst = 1'b0;
    tick();

    // Single write, zero-wait memory
    mem_wait = 0; mem_rdata = '0; mem_resp = 1'b0;
    push_req(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    push_ack(2'b01, 32'h0, 1'b0);
    issue_a(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    tick();
    req_a = '0;
    @(negedge clk); chk("t1_mreq_n1", mreq_a, 1);
    @(negedge clk); chk("t1_ack_n2", ack_a, 2'b01);
    @(negedge clk); chk("t1_ack_n3", ack_a, 2'b00);
    drain("t1_drain");

    // Both ports at once after reset, memory acks two cycles after mreq
    tick(); do_reset();
    mem_wait = 2; mem_rdata = 32'h12345678;
    push_req(32'h100, 1'b1, 32'h11111111, 4'h3);
    push_req(32'h204, 1'b0, 32'h0, 4'hF);
    push_ack(2'b01, 32'h12345678, 1'b0);
    push_ack(2'b10, 32'h12345678, 1'b0);
    issue_a(0, 32'h100, 1'b1, 32'h11111111, 4'h3);
    issue_a(1, 32'h204, 1'b0, 32'h0, 4'hF);
    tick();
    req_a = '0;
    wait_mreq_a("t2_first_mreq");
    @(negedge clk); chk("t2_hold1_addr", maddr_a, 32'h100); chk("t2_hold1_mreq", mreq_a, 0);
    @(negedge clk); chk("t2_hold2_addr", maddr_a, 32'h100); chk("t2_hold2_mreq", mreq_a, 0);
    drain("t2_drain");
    chk("t2_rr_end", dut_a.rr_q, 0);

    // Read with error response
    tick();
    mem_wait = 0; mem_rdata = 32'hCAFEF00D; mem_resp = 1'b1;
    push_req(32'h40, 1'b0, 32'h0, 4'h0);
    push_ack(2'b10, 32'hCAFEF00D, 1'b1);
    issue_a(1, 32'h40, 1'b0, 32'h0, 4'h0);
    tick();
    req_a = '0;
    repeat (3) @(negedge clk);
    chk("t4_ack_low", ack_a, 2'b00);
    chk("t4_rdata_hold", rdata_a, 32'hCAFEF00D);
    chk("t4_resp_hold", resp_a, 1);
    mem_resp = 1'b0;
    drain("t4_drain");

    // Reset while BUSY; the late mack must not produce an ack
    tick();
    mem_wait = 4; mem_rdata = 32'h0;
    push_req(32'h80, 1'b1, 32'hAAAA5555, 4'hF);
    issue_a(0, 32'h80, 1'b1, 32'hAAAA5555, 4'hF);
    tick();
    req_a = '0;
    wait_mreq_a("t5_mreq");
    tick();
    arst = 1'b1;
    @(negedge clk);
    chk("t5_rst_mreq", mreq_a, 0);
    chk("t5_rst_ack", ack_a, 0);
    chk("t5_rst_pend", dut_a.pend_q, 0);
    tick();
    arst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_mem_done", mem_busy, 0);
    tick();
    mem_wait = 0; mem_rdata = 32'h5A5A0001;
    push_req(32'h90, 1'b0, 32'h0, 4'h1);
    push_ack(2'b10, 32'h5A5A0001, 1'b0);
    issue_a(1, 32'h90, 1'b0, 32'h0, 4'h1);
    tick();
    req_a = '0;
    drain("t5_drain");

    // Duplicate request while pending is dropped
    tick();
    mem_wait = 3; mem_rdata = 32'h00000010;
    push_req(32'h10, 1'b0, 32'h0, 4'h0);
    push_ack(2'b01, 32'h00000010, 1'b0);
    issue_a(0, 32'h10, 1'b0, 32'h0, 4'h0);
    tick();
    issue_a(0, 32'h20, 1'b0, 32'h0, 4'h0);
    tick();
    req_a = '0;
    drain("t6_drain");
    repeat (5) @(negedge clk);

    // Three-port fairness
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        exp_b_gnt_q.push_back(p);
        exp_b_ack_q.push_back(p);
      end
    end
    tick();
    b_start = 1'b1;
    begin
      int i = 0;
      while ((exp_b_gnt_q.size() != 0 || exp_b_ack_q.size() != 0) && i < 40) begin
        @(negedge clk);
        i++;
      end
    end
    repeat (3) @(negedge clk);
    chk("b_grants_left", exp_b_gnt_q.size(), 0);
    chk("b_acks_left", exp_b_ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Round-robin arbiter sharing one downstream memory port (mreq/mack protocol) among NUM_REQ requesters, each typically an APB-to-memory bridge. Each requester's single-cycle request is captured into a per-port pending buffer. Buffered requests are issued downstream one at a time, with one transaction outstanding. The response is routed back to the originator as a registered single-cycle ack.

Parameters:
NUM_REQ, 2, number of requester ports (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
req_i  in  NUM_REQ  per-requester request pulse (one cycle)
addr_i  in  NUM_REQ x ADDR_WIDTH  request address, sampled with req_i
we_i  in  NUM_REQ  write enable, sampled with req_i
wdata_i  in  NUM_REQ x DATA_WIDTH  write data, sampled with req_i
strb_i  in  NUM_REQ x DATA_WIDTH/8  byte strobes, sampled with req_i
ack_o  out  NUM_REQ  per-requester completion pulse
rdata_o  out  DATA_WIDTH  read data, valid with any ack_o bit
resp_o  out  1  error response, valid with any ack_o bit
mreq_o  out  1  downstream request pulse
maddr_o  out  ADDR_WIDTH  downstream address
mwe_o  out  1  downstream write enable
mwdata_o  out  DATA_WIDTH  downstream write data
mstrb_o  out  DATA_WIDTH/8  downstream strobes
mack_i  in  1  downstream acknowledge
mrdata_i  in  DATA_WIDTH  downstream read data
mresp_i  in  1  downstream error

Behaviour:
- Reset (async, arst_i=1) clears the following, all effective immediately:
  - all pending flags and buffers to 0
  - state to IDLE
  - rr pointer to 0
  - grant register to 0
  - ack_o, rdata_o and resp_o to 0
  - mreq_o to 0; maddr_o, mwe_o, mwdata_o and mstrb_o to 0
- Capture: at each edge where req_i[i]=1 and pending[i]=0, set pending[i] and latch addr/we/wdata/strb[i].
- req_i[i] while pending[i]=1 is a protocol violation. It is ignored and the buffer is unchanged. A simulation assertion flags it.
- Arbitration: compute combinationally over the pending vector. Search starts at rr_q and increases modulo NUM_REQ. The first pending port wins (index g).
- FSM states: IDLE, BUSY.
- IDLE with any pending:
  - mreq_o=1 for this cycle only; m* outputs are driven from buffer g.
  - If mack_i=1 in the same cycle, the transaction completes and the state stays IDLE.
  - Otherwise grant_q<=g and the state goes to BUSY.
- IDLE with nothing pending: mreq_o=0, m* outputs show buffer rr_q (don't-care), and mack_i is ignored.
- BUSY:
  - mreq_o=0; m* outputs are driven from buffer grant_q and held stable.
  - On mack_i=1 the transaction completes and the state goes to IDLE.
  - No timeout.
- Completion of port g:
  - clear pending[g]
  - rr_q <= (g+1) mod NUM_REQ
  - next cycle: ack_o[g]=1, rdata_o=mrdata_i, resp_o=mresp_i (registered)
  - ack_o is a one-cycle pulse; rdata_o and resp_o hold until the next completion.
- Latency with a zero-wait memory: req_i at edge N gives mreq_o in cycle N+1 and ack_o in cycle N+2. Back-to-back grants are possible on consecutive cycles.
- Simultaneous events:
  - New requests captured in the cycle of an arbitration are eligible from the next cycle.
  - A requester may re-request in the cycle its ack_o is high; capture succeeds because pending was already cleared.
- Reset mid-BUSY abandons the transaction. No ack_o is issued, and a late mack_i arriving in IDLE is ignored.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY) and an index-width function (clog2 of NUM_REQ).
- Sub-module rr_pick: inputs are the pending vector and rr pointer; outputs are valid, one-hot grant and grant index. Purely combinational.
- Top level holds the buffers, FSM and response registers.

Test Plan:
- Single write, zero-wait memory:
  - Stimulus: port0 req at N with addr 0x10, we 1, wdata 0xDEADBEEF, strb 0xF; mack_i=1 with mreq_o.
  - Required: mreq_o in N+1 with exactly those values; ack_o=01 in N+2, resp_o=0; ack_o low in N+3.
- Both ports request in the same cycle after reset, memory acks 2 cycles after mreq:
  - Required: port0 is granted first and maddr_o is held for 2 cycles; then port1; ack_o order 01 then 10; rr_q ends at 0.
- NUM_REQ=3, all ports re-request on every ack, zero-wait memory:
  - Required: grant sequence 0,1,2,0,1,2; no port is starved.
- Read with error:
  - Stimulus: port1 read addr 0x40; memory returns mrdata 0xCAFEF00D with mresp 1.
  - Required: ack_o=10, rdata_o=0xCAFEF00D, resp_o=1; both hold after the pulse.
- Reset asserted while BUSY, then mack_i arrives after release:
  - Required: mreq_o=0, all pending cleared, no ack_o pulse; a following new request is serviced normally.
- Duplicate request while pending:
  - Stimulus: port0 req addr 0x10, then req addr 0x20 before its ack.
  - Required: only addr 0x10 appears on maddr_o; exactly one ack_o[0]; the assertion fires.
